// File: rtl/bht_resolver.sv
// Branch history table with saturating counters, a one-deep pending update stage,
// an init sweep after reset/flush and accuracy statistics. Optional macro: BHT_GSHARE_EN.
module bht_resolver #(
  parameter int INDEX_BITS = 6,
  parameter int CTR_WIDTH  = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_flush,
  input  logic [INDEX_BITS-1:0] i_lk_index,
  output logic                  o_lk_prediction,
  input  logic                  i_res_valid,
  output logic                  o_res_ready,
  input  logic [INDEX_BITS-1:0] i_res_index,
  input  logic                  i_res_taken,
  input  logic                  i_res_predicted,
  output logic                  o_busy,
  input  logic                  i_stats_clear,
  output logic [CNT_WIDTH-1:0]  o_resolve_count,
  output logic [CNT_WIDTH-1:0]  o_mispredict_count
);

  localparam int                    DEPTH      = 1 << INDEX_BITS;
  localparam logic [CTR_WIDTH-1:0]  CTR_MAX    = '1;
  localparam logic [CTR_WIDTH-1:0]  WEAK_T     = ~(CTR_MAX >> 1);
  localparam logic [INDEX_BITS-1:0] SWEEP_LAST = '1;
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = '1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [INDEX_BITS-1:0]   r_sweep_idx;
  logic [INDEX_BITS-1:0]   w_sweep_idx_next;
  logic [CTR_WIDTH-1:0]    r_table [DEPTH];

  logic                    r_pend_valid;
  logic [INDEX_BITS-1:0]   r_pend_idx;
  logic                    r_pend_taken;
  logic                    r_pend_pred;

  logic [CNT_WIDTH-1:0]    r_resolve_count;
  logic [CNT_WIDTH-1:0]    r_mispredict_count;

  logic [INDEX_BITS-1:0]   w_lk_addr;
  logic [INDEX_BITS-1:0]   w_res_addr;
  logic                    w_accept;
  logic                    w_commit;
  logic                    w_init_we;
  logic [CTR_WIDTH-1:0]    w_old_ctr;
  logic [CTR_WIDTH-1:0]    w_new_ctr;

`ifdef BHT_GSHARE_EN
  logic [INDEX_BITS-1:0]   r_ghr;

  assign w_lk_addr  = i_lk_index ^ r_ghr;
  assign w_res_addr = i_res_index ^ r_ghr;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ghr <= '0;
    end else if (i_flush) begin
      r_ghr <= '0;
    end else if (w_accept) begin
      r_ghr <= (r_ghr << 1) | INDEX_BITS'(i_res_taken);
    end
  end
`else
  assign w_lk_addr  = i_lk_index;
  assign w_res_addr = i_res_index;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= ST_INIT;
      r_sweep_idx <= '0;
    end else begin
      r_state     <= w_state_next;
      r_sweep_idx <= w_sweep_idx_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_sweep_idx_next = r_sweep_idx;
    o_busy           = 1'b0;
    o_res_ready      = 1'b0;
    case (r_state)
      ST_INIT: begin
        o_busy = 1'b1;
        if (i_flush) begin
          w_sweep_idx_next = '0;
        end else begin
          w_sweep_idx_next = r_sweep_idx + 1'b1;
          if (r_sweep_idx == SWEEP_LAST) begin
            w_state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        o_res_ready = 1'b1;
        if (i_flush) begin
          w_state_next     = ST_INIT;
          w_sweep_idx_next = '0;
        end
      end
      default: begin
        w_state_next     = ST_INIT;
        w_sweep_idx_next = '0;
      end
    endcase
  end

  // A flush wins over both the incoming handshake and the pending write.
  assign w_accept  = i_res_valid & o_res_ready & ~i_flush;
  assign w_commit  = r_pend_valid & ~i_flush;
  assign w_init_we = (r_state == ST_INIT) & ~i_flush;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pend_valid <= 1'b0;
      r_pend_idx   <= '0;
      r_pend_taken <= 1'b0;
      r_pend_pred  <= 1'b0;
    end else begin
      r_pend_valid <= w_accept;
      if (w_accept) begin
        r_pend_idx   <= w_res_addr;
        r_pend_taken <= i_res_taken;
        r_pend_pred  <= i_res_predicted;
      end
    end
  end

  // Reading after the previous edge's write makes back-to-back same-index updates chain.
  assign w_old_ctr = r_table[r_pend_idx];

  always_comb begin
    w_new_ctr = w_old_ctr;
    if (r_pend_taken) begin
      if (w_old_ctr != CTR_MAX) w_new_ctr = w_old_ctr + 1'b1;
    end else begin
      if (w_old_ctr != '0) w_new_ctr = w_old_ctr - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_init_we) begin
      r_table[r_sweep_idx] <= WEAK_T;
    end else if (w_commit) begin
      r_table[r_pend_idx] <= w_new_ctr;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_resolve_count    <= '0;
      r_mispredict_count <= '0;
    end else if (i_stats_clear) begin
      r_resolve_count    <= '0;
      r_mispredict_count <= '0;
    end else if (w_commit) begin
      if (r_resolve_count != CNT_MAX) r_resolve_count <= r_resolve_count + 1'b1;
      if ((r_pend_taken != r_pend_pred) && (r_mispredict_count != CNT_MAX)) begin
        r_mispredict_count <= r_mispredict_count + 1'b1;
      end
    end
  end

  assign o_resolve_count    = r_resolve_count;
  assign o_mispredict_count = r_mispredict_count;
  assign o_lk_prediction    = (r_state == ST_INIT) ? 1'b1 : r_table[w_lk_addr][CTR_WIDTH-1];

endmodule

// File: tb/tb_bht_resolver.sv
// Directed plus randomized bench for bht_resolver; expectations come from a
// counter-array model that applies each accepted outcome one edge later.
module tb_bht_resolver;

  localparam int IB    = 6;
  localparam int CW    = 2;
  localparam int NW    = 16;
  localparam int DEPTH = 1 << IB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic [IB-1:0] lk = '0;
  logic          valid = 1'b0;
  logic [IB-1:0] ridx = '0;
  logic          taken = 1'b0;
  logic          predicted = 1'b0;
  logic          sclr = 1'b0;

  logic          pred_o;
  logic          ready_o;
  logic          busy_o;
  logic [NW-1:0] rc_o;
  logic [NW-1:0] mc_o;

  bht_resolver #(.INDEX_BITS(IB), .CTR_WIDTH(CW), .CNT_WIDTH(NW)) dut (
    .i_clk              (clk),
    .i_reset_n          (rst_n),
    .i_flush            (flush),
    .i_lk_index         (lk),
    .o_lk_prediction    (pred_o),
    .i_res_valid        (valid),
    .o_res_ready        (ready_o),
    .i_res_index        (ridx),
    .i_res_taken        (taken),
    .i_res_predicted    (predicted),
    .o_busy             (busy_o),
    .i_stats_clear      (sclr),
    .o_resolve_count    (rc_o),
    .o_mispredict_count (mc_o)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer counters and a sweep countdown.
  int ctr [DEPTH];
  int sweep_left;
  bit m_pv;
  int m_pidx;
  bit m_ptk;
  bit m_ppd;
  int m_rc;
  int m_mc;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) ctr[i] = 2;
    sweep_left = DEPTH;
    m_pv = 1'b0;
    m_rc = 0;
    m_mc = 0;
  endfunction

  function automatic void model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (sweep_left > 0) begin
      if (flush) sweep_left = DEPTH;
      else sweep_left--;
    end else if (flush) begin
      m_pv = 1'b0;
      sweep_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) ctr[i] = 2;
    end else begin
      if (m_pv) begin
        if (m_ptk) ctr[m_pidx] = (ctr[m_pidx] == 3) ? 3 : ctr[m_pidx] + 1;
        else       ctr[m_pidx] = (ctr[m_pidx] == 0) ? 0 : ctr[m_pidx] - 1;
        if (!sclr) begin
          m_rc = (m_rc == 65535) ? m_rc : m_rc + 1;
          if (m_ptk != m_ppd) m_mc = (m_mc == 65535) ? m_mc : m_mc + 1;
        end
      end
      m_pv   = valid;
      m_pidx = int'(ridx);
      m_ptk  = taken;
      m_ppd  = predicted;
    end
    if (sclr) begin
      m_rc = 0;
      m_mc = 0;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    bit m_busy;
    m_busy = (sweep_left > 0);
    check({tag, ".busy"}, 32'(busy_o), 32'(m_busy));
    check({tag, ".ready"}, 32'(ready_o), 32'(!m_busy));
    check({tag, ".pred"}, 32'(pred_o), m_busy ? 32'd1 : 32'(ctr[int'(lk)] >= 2));
    check({tag, ".rc"}, 32'(rc_o), 32'(m_rc));
    check({tag, ".mc"}, 32'(mc_o), 32'(m_mc));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic resolve(input string tag, input int idx, input bit tk, input bit pd);
    valid = 1'b1;
    ridx = IB'(idx);
    taken = tk;
    predicted = pd;
    step(tag);
    valid = 1'b0;
    $display("resolve %s idx=%0d taken=%0d predicted=%0d lk=%0d pred=%0d rc=%0d mc=%0d",
             tag, idx, tk, pd, lk, pred_o, rc_o, mc_o);
  endtask

  task automatic look(input int idx);
    lk = IB'(idx);
    #1;
    check($sformatf("look%0d", idx), 32'(pred_o), (sweep_left > 0) ? 32'd1 : 32'(ctr[idx] >= 2));
  endtask

  initial begin
    int rc_snap;

    // 1. reset and init sweep
    #1 rst_n = 1'b0;
    model_reset();
    #1 check_outputs("reset");
    repeat (3) step("in_reset");
    rst_n = 1'b1;
    repeat (DEPTH - 1) step("sweep");
    check("sweep_busy_63", 32'(busy_o), 32'd1);
    step("sweep_end");
    check("sweep_done_64", 32'(busy_o), 32'd0);
    look(0);
    look(31);
    look(63);

    // 2. taken saturation then decay on idx 5
    lk = 5;
    repeat (3) resolve("t2_tk", 5, 1'b1, 1'b1);
    resolve("t2_nt", 5, 1'b0, 1'b1);
    resolve("t2_nt", 5, 1'b0, 1'b1);
    check("t2_prewrite", 32'(pred_o), 32'd1);
    step("t2_post");
    check("t2_final", 32'(pred_o), 32'd0);

    // 3. not-taken saturation on idx 7
    lk = 7;
    repeat (4) resolve("t3_nt", 7, 1'b0, 1'b0);
    resolve("t3_tk", 7, 1'b1, 1'b0);
    step("t3_post");
    check("t3_final", 32'(pred_o), 32'd0);

    // 4. back-to-back same index
    sclr = 1'b1;
    step("t4_clr");
    sclr = 1'b0;
    lk = 9;
    resolve("t4_a", 9, 1'b0, 1'b1);
    resolve("t4_b", 9, 1'b0, 1'b1);
    step("t4_post");
    check("t4_rc", 32'(rc_o), 32'd2);
    resolve("t4_c", 9, 1'b1, 1'b0);
    step("t4_probe");
    check("t4_ctr00", 32'(pred_o), 32'd0);

    // 5. statistics: 10 resolves, 3 mispredicts
    sclr = 1'b1;
    step("t5_clr");
    sclr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bit tk;
      tk = 1'($urandom_range(0, 1));
      resolve("t5", 20 + i, tk, (i % 3 == 1) ? !tk : tk);
    end
    step("t5_post");
    check("t5_rc", 32'(rc_o), 32'd10);
    check("t5_mc", 32'(mc_o), 32'd3);
    sclr = 1'b1;
    step("t5_clear");
    sclr = 1'b0;
    check("t5_rc0", 32'(rc_o), 32'd0);
    check("t5_mc0", 32'(mc_o), 32'd0);

    // 6. flush with pending update on idx 12
    lk = 12;
    resolve("t6_setup", 12, 1'b1, 1'b0);
    step("t6_commit");
    rc_snap = int'(rc_o);
    resolve("t6_drop", 12, 1'b1, 1'b0);
    flush = 1'b1;
    step("t6_flush");
    flush = 1'b0;
    check("t6_rc_hold", 32'(rc_o), 32'(rc_snap));
    repeat (DEPTH - 1) step("t6_sweep");
    check("t6_busy_63", 32'(busy_o), 32'd1);
    step("t6_sweep_end");
    check("t6_busy_64", 32'(busy_o), 32'd0);
    check("t6_pred", 32'(pred_o), 32'd1);
    resolve("t6_nt", 12, 1'b0, 1'b1);
    step("t6_probe");
    check("t6_ctr10", 32'(pred_o), 32'd0);

    // 7. randomized traffic with an asynchronous reset in the middle
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        valid = 1'b0;
        flush = 1'b0;
        sclr  = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_outputs("rnd_async_reset");
        step("rnd_in_reset");
        rst_n = 1'b1;
      end
      valid     = 1'($urandom_range(0, 1));
      ridx      = IB'($urandom_range(0, 15));
      taken     = 1'($urandom_range(0, 1));
      predicted = 1'($urandom_range(0, 1));
      lk        = IB'($urandom_range(0, 15));
      flush     = ($urandom_range(0, 49) == 0);
      sclr      = ($urandom_range(0, 39) == 0);
      step("rnd");
    end
    valid = 1'b0;
    flush = 1'b0;
    sclr  = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
